// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the four requesters, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_finish;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        err;
    logic        busy;

    modport slave (
        input  req, req_data, tx_finish,
        output tx_data, tx_start, gnt, ack, err, busy
    );

    modport master (
        output req, req_data, tx_finish,
        input  tx_data, tx_start, gnt, ack, err, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters,
// with a per-frame completion timeout and an optional inter-frame idle gap.
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 60000,
    parameter int unsigned GAP_CYCLES     = 16
) (
    input logic            clk,
    input logic            rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, GAP} state_t;

    state_t        state;
    logic [1:0]    last_winner;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;
    logic [TW-1:0] wait_cnt;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    tx_data_q;
    logic          tx_start_q;
    logic [3:0]    gnt_q;
    logic [3:0]    ack_q;
    logic          err_q;
    logic          busy_q;

    // Search starts one past the previous winner and wraps, so every
    // requester is served within four transactions.
    always_comb begin
        winner = last_winner;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = last_winner + 2'd1 + 2'(i);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= 2'd3;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            gnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= START;
                        gnt_q       <= 4'b0001 << winner;
                        tx_data_q   <= bus.req_data[{winner, 3'b000} +: 8];
                        last_winner <= winner;
                        tx_start_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                START: begin
                    tx_start_q <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // tx_finish has priority over an expiring timeout
                    if (bus.tx_finish) begin
                        state <= DONE;
                        ack_q <= gnt_q;
                    end else if (wait_cnt == T_LAST) begin
                        state <= DONE;
                        ack_q <= gnt_q;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    err_q   <= 1'b0;
                    gnt_q   <= '0;
                    gap_cnt <= '0;
                    if (GAP_CYCLES > 0) begin
                        state <= GAP;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == G_LAST) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.gnt      = gnt_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// frames, checked against a transaction-level round-robin/timing model.
module tb_uart_tx_arbiter;
    localparam int TO  = 20;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lw = 3;

    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next owner: first requesting index after the previous winner, wrapping.
    function automatic int pick(input logic [3:0] r);
        for (int i = 1; i <= 4; i++)
            if (r[(lw + i) % 4]) return (lw + i) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.tx_finish = 1'b0;
        repeat (3) tick();
        chk("reset_outs", {13'd0, bus.tx_data, bus.tx_start, bus.gnt, bus.ack, bus.err, bus.busy}, 32'd0);
        rst = 1'b0;
        lw = 3;
    endtask

    // One frame from IDLE to IDLE. fin: cycle after tx_start on which
    // tx_finish is pulsed (0 = never). Enters and leaves in an IDLE cycle.
    task automatic do_frame(input logic [3:0] r, input logic [31:0] d, input int fin,
                            input bit drop, input bit spur, output logic [7:0] seen);
        int win, n, ack_at, exp_at, gap;
        logic [7:0] b;
        logic [3:0] g;
        bit stable;
        win = pick(r);
        b = d[8*win +: 8];
        g = 4'(1 << win);
        bus.req = r;
        bus.req_data = d;
        bus.tx_finish = spur;
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        seen = bus.tx_data;
        chk("start_latency", n, 1);
        chk("gnt", {28'd0, bus.gnt}, {28'd0, g});
        chk("tx_data", {24'd0, bus.tx_data}, {24'd0, b});
        chk("busy_start", {31'd0, bus.busy}, 32'd1);
        lw = win;
        ack_at = 0;
        stable = 1'b1;
        for (int k = 1; k <= TO + 5; k++) begin
            tick();
            bus.tx_finish = (k == fin);
            if (drop && k == 2) begin
                bus.req = 4'($urandom);
                bus.req_data = $urandom;
            end
            if (bus.tx_start !== 1'b0 || bus.gnt !== g || bus.tx_data !== b || bus.busy !== 1'b1)
                stable = 1'b0;
            if (bus.ack !== 4'd0) begin
                ack_at = k;
                break;
            end
        end
        bus.tx_finish = 1'b0;
        exp_at = (fin > 0) ? fin + 1 : TO + 1;
        chk("ack_latency", ack_at, exp_at);
        chk("ack", {28'd0, bus.ack}, {28'd0, g});
        chk("err", {31'd0, bus.err}, {31'd0, (fin == 0)});
        chk("hold_stable", {31'd0, stable}, 32'd1);
        tick();
        chk("done_clear", {19'd0, bus.ack, bus.err, bus.gnt, bus.tx_start}, 32'd0);
        gap = 0;
        while (bus.busy === 1'b1 && gap < 100) begin
            gap++;
            if (spur) bus.tx_finish = 1'($urandom);
            tick();
        end
        bus.tx_finish = 1'b0;
        chk("gap_len", gap, GAP);
    endtask

    initial begin
        logic [7:0] seen;
        logic [7:0] seq [5];
        logic [3:0] r;
        int n;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_finish = 1'b0;

        do_reset();
        repeat (5) tick();
        chk("idle_no_req", {31'd0, bus.busy}, 32'd0);

        // single requester, finish 10 cycles after start
        do_frame(4'b0001, {$urandom_range(0, 255) << 8, 8'hA5}, 10, 1'b0, 1'b0, seen);
        chk("single_byte", {24'd0, seen}, 32'hA5);

        // all requesters held: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_frame(4'b1111, 32'h44332211, $urandom_range(1, TO), 1'b0, 1'b0, seen);
            chk("rr_seq", {24'd0, seen}, {24'd0, seq[i]});
        end

        // timeout with finish never arriving
        do_frame(4'b0100, $urandom, 0, 1'b0, 1'b0, seen);
        // finish exactly on the timeout cycle
        do_frame(4'b1000, $urandom, TO, 1'b0, 1'b0, seen);
        // requester drops and data changes mid-transaction
        do_frame(4'b0010, $urandom, 7, 1'b1, 1'b0, seen);
        // spurious finish in IDLE, START and GAP
        do_frame(4'b0001, $urandom, 5, 1'b0, 1'b1, seen);

        // reset during WAIT abandons the frame
        bus.req = 4'b1111;
        bus.req_data = $urandom;
        n = 0;
        while (bus.tx_start !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_wait", {13'd0, bus.tx_data, bus.tx_start, bus.gnt, bus.ack, bus.err, bus.busy}, 32'd0);
        rst = 1'b0;
        lw = 3;
        do_frame(4'b1111, 32'hDDCCBBAA, 4, 1'b0, 1'b0, seen);
        chk("post_rst_owner", {24'd0, seen}, 32'hAA);

        for (int i = 0; i < 20; i++) begin
            r = 4'($urandom_range(1, 15));
            do_frame(r, $urandom, $urandom_range(0, TO), 1'($urandom), 1'($urandom), seen);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
